// File: rtl/t04_mem_pkg.sv
// Shared types and constants for the memory request unit.
package t04_mem_pkg;

   localparam int unsigned ADDR_W                 = 32;
   localparam int unsigned DATA_W                 = 32;
   localparam int unsigned SEL_W                  = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;
   localparam logic [DATA_W-1:0] TIMEOUT_RDATA    = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_t;

   // Captured request that drives the bus for the whole transaction
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [SEL_W-1:0]  sel;
   } mem_req_t;

endpackage

// File: rtl/t04_req_timer.sv
// Bus-wait cycle counter; expired is high in the LIMIT-th cycle of run.
module t04_req_timer #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (run)   cnt_q <= cnt_q + CW'(1);
   end

   assign expired = run && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/t04_mem_request_unit.sv
// Arbitrates data and instruction requests onto a single bus, one at a time.
// Optional bus-wait abort enabled with T04_REQ_TIMEOUT_EN.
module t04_mem_request_unit
   import t04_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [SEL_W-1:0]  d_sel,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] d_rdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              d_done,
   output logic              i_done,
   output logic              stall,
   output logic              bus_read,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_adr,
   output logic [DATA_W-1:0] bus_wdat,
   output logic [SEL_W-1:0]  bus_sel,
   input  logic [DATA_W-1:0] bus_rdat,
   input  logic              bus_ack,
   output logic              timeout_err
);

   state_t            state_q, state_d;
   mem_req_t          hold_q, hold_d;
   logic              bus_read_d, bus_write_d;
   logic              d_done_d, i_done_d;
   logic [DATA_W-1:0] d_rdata_d, i_rdata_d;
   logic              expired_c;
   logic              busy_c;

   assign busy_c = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, request capture and completion handling
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      bus_read_d  = bus_read;
      bus_write_d = bus_write;
      d_done_d    = 1'b0;
      i_done_d    = 1'b0;
      d_rdata_d   = d_rdata;
      i_rdata_d   = i_rdata;
      unique case (state_q)
         IDLE: begin
            if (!d_done && !i_done) begin
               if (d_read || d_write) begin
                  state_d      = DATA;
                  hold_d.write = d_write && !d_read;
                  hold_d.addr  = d_addr;
                  hold_d.wdata = d_wdata;
                  hold_d.sel   = d_sel;
                  bus_read_d   = !hold_d.write;
                  bus_write_d  = hold_d.write;
               end else if (i_read) begin
                  state_d      = INSTR;
                  hold_d.write = 1'b0;
                  hold_d.addr  = i_addr;
                  hold_d.wdata = '0;
                  hold_d.sel   = '1;
                  bus_read_d   = 1'b1;
                  bus_write_d  = 1'b0;
               end
            end
         end
         DATA, INSTR: begin
            if (bus_ack || expired_c) begin
               state_d     = IDLE;
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
               if (state_q == DATA) begin
                  d_done_d = 1'b1;
                  if (!hold_q.write) d_rdata_d = bus_ack ? bus_rdat : TIMEOUT_RDATA;
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = bus_ack ? bus_rdat : TIMEOUT_RDATA;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= '0;
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
         d_done    <= 1'b0;
         i_done    <= 1'b0;
         d_rdata   <= '0;
         i_rdata   <= '0;
      end else begin
         hold_q    <= hold_d;
         bus_read  <= bus_read_d;
         bus_write <= bus_write_d;
         d_done    <= d_done_d;
         i_done    <= i_done_d;
         d_rdata   <= d_rdata_d;
         i_rdata   <= i_rdata_d;
      end
   end

   assign bus_adr  = hold_q.addr;
   assign bus_wdat = hold_q.wdata;
   assign bus_sel  = hold_q.sel;

   // Freeze the CPU while busy or while a request waits to be accepted
   assign stall = !rst && (busy_c || ((d_read || d_write || i_read) && !d_done && !i_done));

`ifdef T04_REQ_TIMEOUT_EN
   t04_req_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!busy_c && (state_d != IDLE)),
      .run     (busy_c),
      .expired (expired_c)
   );

   // Sticky until reset; an ack in the expiry cycle still wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       timeout_err <= 1'b0;
      else if (expired_c && !bus_ack) timeout_err <= 1'b1;
   end
`else
   assign expired_c   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_t04_mem_request_unit.sv
// Directed self-checking bench for t04_mem_request_unit (timeout section under T04_REQ_TIMEOUT_EN).
module tb_t04_mem_request_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_read, d_write, i_read;
   logic [31:0] d_addr, d_wdata, i_addr;
   logic [3:0]  d_sel;
   logic [31:0] d_rdata, i_rdata;
   logic        d_done, i_done, stall;
   logic        bus_read, bus_write;
   logic [31:0] bus_adr, bus_wdat;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdat;
   logic        bus_ack;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   t04_mem_request_unit #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_sel       (d_sel),
      .i_read      (i_read),
      .i_addr      (i_addr),
      .d_rdata     (d_rdata),
      .i_rdata     (i_rdata),
      .d_done      (d_done),
      .i_done      (i_done),
      .stall       (stall),
      .bus_read    (bus_read),
      .bus_write   (bus_write),
      .bus_adr     (bus_adr),
      .bus_wdat    (bus_wdat),
      .bus_sel     (bus_sel),
      .bus_rdat    (bus_rdat),
      .bus_ack     (bus_ack),
      .timeout_err (timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; d_read = 0; d_write = 0; i_read = 0;
      d_addr = '0; d_wdata = '0; d_sel = '0; i_addr = '0;
      bus_rdat = '0; bus_ack = 0;
      tick(); tick();

      // reset state, including a request held during reset
      d_read = 1'b1;
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_bus_read", 32'(bus_read), 32'd0);
      check("rst_bus_write", 32'(bus_write), 32'd0);
      check("rst_bus_adr", bus_adr, 32'd0);
      check("rst_bus_sel", 32'(bus_sel), 32'd0);
      check("rst_done", {30'd0, d_done, i_done}, 32'd0);
      check("rst_rdata", d_rdata | i_rdata, 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      d_read = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // spurious ack in idle
      bus_ack = 1'b1; bus_rdat = 32'h5555_5555;
      tick();
      bus_ack = 1'b0;
      check("spur_done", {30'd0, d_done, i_done}, 32'd0);
      check("spur_bus_read", 32'(bus_read), 32'd0);
      check("spur_stall", 32'(stall), 32'd0);
      check("spur_d_rdata", d_rdata, 32'd0);

      // load, ack in third bus cycle
      d_read = 1'b1; d_addr = 32'h0000_0100; d_sel = 4'hF; d_wdata = 32'h1234_5678;
      #1;
      check("ld_stall_req", 32'(stall), 32'd1);
      tick();
      check("ld_c1_bus_read", 32'(bus_read), 32'd1);
      check("ld_c1_bus_write", 32'(bus_write), 32'd0);
      check("ld_c1_bus_adr", bus_adr, 32'h0000_0100);
      check("ld_c1_stall", 32'(stall), 32'd1);
      tick();
      check("ld_c2_bus_read", 32'(bus_read), 32'd1);
      tick();
      check("ld_c3_bus_read", 32'(bus_read), 32'd1);
      bus_ack = 1'b1; bus_rdat = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0;
      check("ld_d_done", 32'(d_done), 32'd1);
      check("ld_i_done", 32'(i_done), 32'd0);
      check("ld_d_rdata", d_rdata, 32'hCAFE_F00D);
      check("ld_done_bus_read", 32'(bus_read), 32'd0);
      check("ld_done_stall", 32'(stall), 32'd0);
      d_read = 1'b0;
      tick();
      check("ld_done_pulse", 32'(d_done), 32'd0);

      // store; request changes mid-transaction must not reach the bus
      d_write = 1'b1; d_sel = 4'b0011; d_wdata = 32'h0000_BEEF; d_addr = 32'h0000_0200;
      tick();
      check("st_bus_write", 32'(bus_write), 32'd1);
      check("st_bus_read", 32'(bus_read), 32'd0);
      check("st_bus_sel", 32'(bus_sel), 32'h3);
      check("st_bus_wdat", bus_wdat, 32'h0000_BEEF);
      check("st_bus_adr", bus_adr, 32'h0000_0200);
      d_wdata = 32'h1234_1234; d_sel = 4'hF; d_addr = 32'h0;
      tick();
      check("st_hold_wdat", bus_wdat, 32'h0000_BEEF);
      check("st_hold_sel", 32'(bus_sel), 32'h3);
      check("st_hold_adr", bus_adr, 32'h0000_0200);
      bus_ack = 1'b1; bus_rdat = 32'hDEAD_BEEF;
      tick();
      bus_ack = 1'b0;
      check("st_d_done", 32'(d_done), 32'd1);
      check("st_d_rdata_kept", d_rdata, 32'hCAFE_F00D);
      check("st_done_bus_write", 32'(bus_write), 32'd0);
      d_write = 1'b0;
      tick();

      // data and fetch together at reset release
      rst = 1'b1;
      d_read = 1'b1; i_read = 1'b1; d_addr = 32'h0000_0300; i_addr = 32'h0000_0400;
      tick();
      check("both_rst_d_rdata", d_rdata, 32'd0);
      check("both_rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      tick();
      check("both_data_first", 32'(bus_adr), 32'h0000_0300);
      check("both_data_read", 32'(bus_read), 32'd1);
      bus_ack = 1'b1; bus_rdat = 32'h1111_1111;
      tick();
      bus_ack = 1'b0;
      check("both_d_done", {30'd0, d_done, i_done}, 32'd2);
      check("both_d_rdata", d_rdata, 32'h1111_1111);
      check("both_blackout_stall", 32'(stall), 32'd0);
      d_read = 1'b0;
      tick();
      check("both_gap_bus_read", 32'(bus_read), 32'd0);
      check("both_gap_stall", 32'(stall), 32'd1);
      tick();
      check("fetch_bus_read", 32'(bus_read), 32'd1);
      check("fetch_bus_adr", bus_adr, 32'h0000_0400);
      check("fetch_bus_sel", 32'(bus_sel), 32'hF);
      check("fetch_bus_wdat", bus_wdat, 32'd0);
      bus_ack = 1'b1; bus_rdat = 32'h2222_2222;
      tick();
      bus_ack = 1'b0;
      check("fetch_done", {30'd0, d_done, i_done}, 32'd1);
      check("fetch_i_rdata", i_rdata, 32'h2222_2222);
      check("fetch_d_rdata_kept", d_rdata, 32'h1111_1111);
      i_read = 1'b0;
      tick();
      check("fetch_done_pulse", 32'(i_done), 32'd0);

      // reset two cycles into a data transaction
      d_read = 1'b1; d_addr = 32'h0000_0500;
      tick(); tick();
      check("abort_pre_bus_read", 32'(bus_read), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_bus_read", 32'(bus_read), 32'd0);
      check("abort_bus_adr", bus_adr, 32'd0);
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_rdata", d_rdata | i_rdata, 32'd0);
      bus_ack = 1'b1; bus_rdat = 32'h7777_7777;
      tick();
      check("abort_no_done", {30'd0, d_done, i_done}, 32'd0);
      bus_ack = 1'b0;
      rst = 1'b0;
      tick();
      check("abort_restart_read", 32'(bus_read), 32'd1);
      check("abort_restart_adr", bus_adr, 32'h0000_0500);
      bus_ack = 1'b1; bus_rdat = 32'h3333_3333;
      tick();
      bus_ack = 1'b0;
      check("abort_restart_done", 32'(d_done), 32'd1);
      check("abort_restart_rdata", d_rdata, 32'h3333_3333);
      d_read = 1'b0;
      tick();

`ifdef T04_REQ_TIMEOUT_EN
      // no ack: abort after 8 bus cycles
      d_read = 1'b1; d_addr = 32'h0000_0600;
      tick();
      check("to_c1_bus_read", 32'(bus_read), 32'd1);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check("to_wait_bus_read", 32'(bus_read), 32'd1);
      end
      check("to_wait_err", 32'(timeout_err), 32'd0);
      tick();
      check("to_d_done", 32'(d_done), 32'd1);
      check("to_d_rdata", d_rdata, 32'd0);
      check("to_err", 32'(timeout_err), 32'd1);
      check("to_bus_read", 32'(bus_read), 32'd0);
      d_read = 1'b0;
      tick();
      tick();
      check("to_err_sticky", 32'(timeout_err), 32'd1);
      check("to_done_pulse", 32'(d_done), 32'd0);
      rst = 1'b1;
      #1;
      check("to_err_rst", 32'(timeout_err), 32'd0);
      tick();
      rst = 1'b0;
      tick();
`else
      check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
